// File: rtl/smc_pkg.sv
// Shared types and helpers for the serial SMC front end.
// Latency: n/a (types, constants, pure function).
// Backpressure: n/a.
package smc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CALC  = 3'd2,
    CALC2 = 3'd3,
    OUT   = 3'd4
  } state_t;

  localparam int NUM_TR = 6;
  localparam int DW     = 8;

  // mode[MODE_ID_BIT]=1 selects drain current, else transconductance.
  localparam int MODE_ID_BIT = 0;
  // mode[MODE_HI_BIT]=1 selects the largest three sorted entries.
  localparam int MODE_HI_BIT = 1;

  // floor(x/3) for 0..255 via multiply-by-reciprocal; 171/512 stays exact over this range.
  function automatic logic [7:0] div3(input logic [7:0] x);
    logic [16:0] t;
    t = {9'd0, x} * 17'd171;
    return t[16:9];
  endfunction

endpackage

// File: rtl/smc_idn_unit.sv
// Per-record product W*(Id or gm) for the beat currently presented.
// Latency: combinational.
// Backpressure: none; evaluated whenever inputs change.
module smc_idn_unit
  import smc_pkg::*;
(
  input  logic          is_id,
  input  logic [2:0]    w,
  input  logic [2:0]    v_gs,
  input  logic [2:0]    v_ds,
  output logic [DW-1:0] p
);

  logic [7:0]  vov8;
  logic [7:0]  vds8;
  logic        triode;
  logic [7:0]  val8;
  logic [15:0] prod;

  // Overdrive, region decision and the selected characteristic scaled by W.
  always_comb begin
    vov8   = (v_gs == 3'd0) ? 8'd0 : {5'd0, v_gs - 3'd1};
    vds8   = {5'd0, v_ds};
    triode = (vds8 <= vov8);
    if (is_id) begin
      // In triode V_DS <= Vov, so the subtraction cannot go negative.
      val8 = triode ? (8'd2 * vov8 * vds8 - vds8 * vds8) : (vov8 * vov8);
    end else begin
      val8 = triode ? (vds8 << 1) : (vov8 << 1);
    end
    prod = {8'd0, val8} * {13'd0, w};
    p    = prod[DW-1:0];
  end

endmodule

// File: rtl/smc_stream.sv
// Serial SMC: collects six records into a sorted array, then emits one 8-bit result.
// Latency: out_valid 2 cycles after the 6th beat (3 with SMC_STREAM_PIPE_EN defined).
// Backpressure: none; in_valid during CALC/CALC2/OUT is dropped, a gap in LOAD aborts.
module smc_stream
  import smc_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [1:0]    mode,
  input  logic [2:0]    W,
  input  logic [2:0]    V_GS,
  input  logic [2:0]    V_DS,
  output logic          out_valid,
  output logic [DW-1:0] out_n
);

  state_t      state;
  logic [2:0]  cnt;
  logic [1:0]  mode_q;
  logic [7:0]  s   [NUM_TR];
  logic [7:0]  ins [NUM_TR];
  logic [2:0]  pos;
  logic        is_id;
  logic [7:0]  p;
  logic [7:0]  da, db, dc;
  logic [7:0]  ua, ub, uc;
  logic [9:0]  id_sum, gm_sum;
  logic [9:0]  id_q, gm_q;
  logic [7:0]  res;

  // Mode is only valid on the wire for the first beat; later beats use the latched copy.
  assign is_id = (state == IDLE) ? mode[MODE_ID_BIT] : mode_q[MODE_ID_BIT];

  smc_idn_unit u_idn (
    .is_id (is_id),
    .w     (W),
    .v_gs  (V_GS),
    .v_ds  (V_DS),
    .p     (p)
  );

  // Insert p after every valid entry <= p; entries are ascending so that set is a prefix.
  always_comb begin
    pos = 3'd0;
    for (int i = 0; i < NUM_TR; i++) begin
      if ((3'(i) < cnt) && (s[i] <= p)) pos = pos + 3'd1;
    end
    ins[0] = (pos == 3'd0) ? p : s[0];
    for (int i = 1; i < NUM_TR; i++) begin
      if (3'(i) < pos)       ins[i] = s[i];
      else if (3'(i) == pos) ins[i] = p;
      else                   ins[i] = s[i-1];
    end
  end

  // Pick the lower or upper half of the sorted array and divide each entry by 3.
  always_comb begin
    if (mode_q[MODE_HI_BIT]) begin
      da = div3(s[3]);
      db = div3(s[4]);
      dc = div3(s[5]);
    end else begin
      da = div3(s[0]);
      db = div3(s[1]);
      dc = div3(s[2]);
    end
  end

`ifdef SMC_STREAM_PIPE_EN
  logic [7:0] pa, pb, pc;
  assign ua = pa;
  assign ub = pb;
  assign uc = pc;
`else
  assign ua = da;
  assign ub = db;
  assign uc = dc;
`endif

  // Weighted sum favours the smallest (a) for Id; plain mean for gm.
  always_comb begin
    id_sum = 10'd3 * {2'd0, uc} + 10'd4 * {2'd0, ub} + 10'd5 * {2'd0, ua};
    gm_sum = {2'd0, ua} + {2'd0, ub} + {2'd0, uc};
    id_q   = id_sum / 10'd12;
    gm_q   = gm_sum / 10'd3;
    res    = mode_q[MODE_ID_BIT] ? id_q[7:0] : gm_q[7:0];
  end

  // Control FSM with registered result strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      mode_q    <= 2'd0;
      out_valid <= 1'b0;
      out_n     <= '0;
      for (int i = 0; i < NUM_TR; i++) s[i] <= 8'd0;
`ifdef SMC_STREAM_PIPE_EN
      pa <= 8'd0;
      pb <= 8'd0;
      pc <= 8'd0;
`endif
    end else begin
      out_valid <= 1'b0;
      out_n     <= '0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            mode_q <= mode;
            s[0]   <= p;
            for (int i = 1; i < NUM_TR; i++) s[i] <= 8'd0;
            cnt    <= 3'd1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid) begin
            s   <= ins;
            cnt <= cnt + 3'd1;
            if (cnt == 3'(NUM_TR - 1)) state <= CALC;
          end else begin
            cnt   <= 3'd0;
            state <= IDLE;
          end
        end
        CALC: begin
`ifdef SMC_STREAM_PIPE_EN
          pa    <= da;
          pb    <= db;
          pc    <= dc;
          state <= CALC2;
`else
          out_valid <= 1'b1;
          out_n     <= res;
          state     <= OUT;
`endif
        end
        CALC2: begin
          out_valid <= 1'b1;
          out_n     <= res;
          state     <= OUT;
        end
        OUT: begin
          cnt   <= 3'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
